// File: rtl/spgd_dac_pkg.sv
// Shared widths, reset code and FSM state encoding for the SPGD DAC slew path.
package spgd_dac_pkg;

  localparam int DAC_WIDTH = 14;

  function automatic int unsigned midscale_of(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  localparam int unsigned MIDSCALE = midscale_of(DAC_WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RAMP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

endpackage

// File: rtl/spgd_tick_div.sv
// Ramp-step prescaler: tick is high one cycle in TICK_DIV; clear restarts the count
// so the first tick lands exactly TICK_DIV edges after the clearing edge.
module spgd_tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/spgd_dac_ramp.sv
// Slews the DAC code toward an accepted offset-binary target in bounded steps, holds for
// settle_cycles, then pulses settled; new targets are only taken while idle (target_ready).
module spgd_dac_ramp
  import spgd_dac_pkg::*;
#(
  parameter int WIRE_WIDTH   = DAC_WIDTH,
  parameter int STEP_WIDTH   = 8,
  parameter int SETTLE_WIDTH = 16,
  parameter int TICK_DIV     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIRE_WIDTH-1:0]   target_in,
  input  logic                    target_valid,
  output logic                    target_ready,
  input  logic [STEP_WIDTH-1:0]   step_size,
  input  logic [SETTLE_WIDTH-1:0] settle_cycles,
  output logic [WIRE_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    settled
);

  localparam int unsigned           MID_INT = (WIRE_WIDTH == DAC_WIDTH) ? MIDSCALE
                                                                         : midscale_of(WIRE_WIDTH);
  localparam logic [WIRE_WIDTH-1:0] MID     = WIRE_WIDTH'(MID_INT);

  logic [1:0]              r_state;
  logic [WIRE_WIDTH-1:0]   r_target;
  logic [STEP_WIDTH-1:0]   r_step;
  logic [SETTLE_WIDTH-1:0] r_settle;
  logic [SETTLE_WIDTH-1:0] r_cnt;
  logic [WIRE_WIDTH-1:0]   r_data;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_settled;

  logic                    w_accept;
  logic                    w_tick;
  logic                    w_close;
  logic                    w_settle_done;
  logic [1:0]              w_state_nxt;
  logic signed [WIRE_WIDTH:0] w_diff;
  logic [WIRE_WIDTH:0]     w_mag;
  logic [WIRE_WIDTH:0]     w_step_ext;
  logic [WIRE_WIDTH-1:0]   w_next_data;

  assign w_accept = target_valid && r_ready;

  spgd_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Both operands are zero-extended, so the difference cannot overflow and
  // the partial final step lands exactly on the target without wrapping.
  assign w_diff      = $signed({1'b0, r_target}) - $signed({1'b0, r_data});
  assign w_mag       = w_diff[WIRE_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_step_ext  = (WIRE_WIDTH + 1)'(r_step);
  assign w_close     = (w_mag <= w_step_ext);
  assign w_next_data = w_diff[WIRE_WIDTH] ? (r_data - w_step_ext[WIRE_WIDTH-1:0])
                                          : (r_data + w_step_ext[WIRE_WIDTH-1:0]);

  assign w_settle_done = (r_state == SETTLE) && !r_settled && (r_cnt == r_settle);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)           w_state_nxt = RAMP;
      RAMP:    if (w_tick && w_close)  w_state_nxt = SETTLE;
      SETTLE:  if (r_settled)          w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_settled <= w_settle_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= MID;
      r_step   <= STEP_WIDTH'(1);
      r_settle <= '0;
    end else if (w_accept) begin
      r_target <= target_in;
      r_step   <= (step_size == '0) ? STEP_WIDTH'(1) : step_size;
      r_settle <= settle_cycles;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= MID;
    end else if ((r_state == RAMP) && w_tick) begin
      r_data <= w_close ? r_target : w_next_data;
    end
  end

  // Counter holds at the match value while the settled pulse is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != SETTLE) begin
      r_cnt <= '0;
    end else if (r_cnt != r_settle) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign target_ready = r_ready;
  assign busy         = r_busy;
  assign settled      = r_settled;
  assign data_out     = r_data;

endmodule

// File: tb/tb_spgd_dac_ramp.sv
// Bench for spgd_dac_ramp: instance 0 (TICK_DIV=1) and instance 1 (TICK_DIV=3) each checked
// every cycle against a per-transaction trace model, plus literal checks of the documented cases.
module tb_spgd_dac_ramp;

  localparam int W = 14;
  localparam logic [W-1:0] MID = 14'h2000;
  localparam int WAIT_MAX = 4000;

  typedef struct packed {
    logic [W-1:0] data;
    logic         rdy;
    logic         busy;
    logic         sett;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [2];
  logic [W-1:0] tin  [2];
  logic         tv   [2];
  logic [7:0]   stp  [2];
  logic [15:0]  stl  [2];
  logic [W-1:0] dout [2];
  logic         trdy [2];
  logic         busy [2];
  logic         sett [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(input int unsigned d, input logic r, input logic b, input logic s);
    exp_t e;
    e.data = W'(d);
    e.rdy  = r;
    e.busy = b;
    e.sett = s;
    return e;
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int D = (g == 0) ? 1 : 3;
    exp_t         q[$];
    logic [W-1:0] last    = MID;
    bit           m_ready = 1'b1;

    spgd_dac_ramp #(
      .WIRE_WIDTH   (W),
      .STEP_WIDTH   (8),
      .SETTLE_WIDTH (16),
      .TICK_DIV     (D)
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .target_in     (tin[g]),
      .target_valid  (tv[g]),
      .target_ready  (trdy[g]),
      .step_size     (stp[g]),
      .settle_cycles (stl[g]),
      .data_out      (dout[g]),
      .busy          (busy[g]),
      .settled       (sett[g])
    );

    // Whole expected per-cycle trace of one transaction, from the accept edge onward.
    function automatic void build(input int unsigned tgt, input int unsigned s_in,
                                  input int unsigned settle);
      int unsigned cur = last;
      int unsigned s   = (s_in == 0) ? 1 : s_in;
      q.push_back(mk(cur, 1'b0, 1'b1, 1'b0));
      do begin
        for (int k = 1; k < D; k++) q.push_back(mk(cur, 1'b0, 1'b1, 1'b0));
        if (cur > tgt) cur = (cur - tgt <= s) ? tgt : cur - s;
        else           cur = (tgt - cur <= s) ? tgt : cur + s;
        q.push_back(mk(cur, 1'b0, 1'b1, 1'b0));
      end while (cur != tgt);
      for (int k = 0; k < int'(settle); k++) q.push_back(mk(cur, 1'b0, 1'b1, 1'b0));
      q.push_back(mk(cur, 1'b0, 1'b1, 1'b1));
      last = W'(tgt);
    endfunction

    always @(posedge clk) begin
      if (!rst[g] && m_ready && tv[g]) build(tin[g], stp[g], stl[g]);
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst[g]) begin
        q.delete();
        last = MID;
        e = mk(MID, 1'b1, 1'b0, 1'b0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
      end else begin
        e = mk(last, 1'b1, 1'b0, 1'b0);
      end
      m_ready = e.rdy;
      n_cmp++;
      if ({dout[g], trdy[g], busy[g], sett[g]} !== e) begin
        n_bad++;
        $display("FAIL trace[%0d] t=%0t: got data=%h rdy=%b busy=%b settled=%b, want data=%h rdy=%b busy=%b settled=%b",
                 g, $time, dout[g], trdy[g], busy[g], sett[g], e.data, e.rdy, e.busy, e.sett);
      end
    end
  end

  task automatic send(input int g, input logic [W-1:0] t, input logic [7:0] s, input logic [15:0] c);
    tv[g] = 1'b1; tin[g] = t; stp[g] = s; stl[g] = c;
    @(posedge clk); #1;
    tv[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(trdy[g] === 1'b1 && busy[g] === 1'b0) && n < WAIT_MAX);
    n_cmp++;
    if (n >= WAIT_MAX) begin
      n_bad++;
      $display("FAIL %s: still busy after %0d cycles, want idle", name, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned seq2 [4];
    int unsigned seq6 [10];
    int unsigned cur;
    int          t;

    seq2 = '{32'h2004, 32'h2008, 32'h200C, 32'h2010};
    seq6 = '{32'h2000, 32'h2000, 32'h2000, 32'h2001, 32'h2001,
             32'h2001, 32'h2002, 32'h2002, 32'h2002, 32'h2003};
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; tv[g] = 1'b0; tin[g] = '0; stp[g] = '0; stl[g] = '0;
    end

    repeat (3) @(negedge clk);
    lit("reset data_out", dout[0], 32'h2000);
    lit("reset ready",    trdy[0], 1);
    lit("reset busy",     busy[0], 0);
    lit("reset settled",  sett[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    send(0, 14'h2010, 8'd4, 16'd0);
    @(negedge clk); lit("t2 busy after accept", busy[0], 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lit("t2 ramp code", dout[0], seq2[i]);
    end
    @(negedge clk); lit("t2 settled pulse", sett[0], 1);
    @(negedge clk); lit("t2 ready after pulse", trdy[0], 1);
    lit("t2 settled one cycle", sett[0], 0);

    @(posedge clk); #1; rst[0] = 1'b1;
    @(negedge clk); @(posedge clk); #1; rst[0] = 1'b0;
    send(0, 14'h1FF9, 8'd4, 16'd3);
    @(negedge clk);
    @(negedge clk); lit("t3 first step", dout[0], 32'h1FFC);
    @(negedge clk); lit("t3 partial step", dout[0], 32'h1FF9);
    repeat (3) @(negedge clk);
    lit("t3 no early settled", sett[0], 0);
    @(negedge clk); lit("t3 settled after 4 settle cycles", sett[0], 1);
    @(negedge clk); lit("t3 ready after pulse", trdy[0], 1);

    @(posedge clk); #1;
    send(0, 14'h3FFF, 8'd255, 16'd0);
    wait_idle(0, "t4 up");
    lit("t4 top code no wrap", dout[0], 32'h3FFF);
    send(0, 14'h0000, 8'd255, 16'd2);
    wait_idle(0, "t4 down");
    lit("t4 bottom code no wrap", dout[0], 32'h0000);

    send(0, 14'h0040, 8'd0, 16'd1);
    @(negedge clk);
    @(negedge clk); lit("t5 step0 first", dout[0], 32'h0001);
    @(negedge clk); lit("t5 step0 second", dout[0], 32'h0002);
    @(posedge clk); #1;
    tv[0] = 1'b1; tin[0] = 14'h0123; stp[0] = 8'd200; stl[0] = 16'd0;
    @(posedge clk); #1;
    tv[0] = 1'b0;
    wait_idle(0, "t5 ramp");
    lit("t5 ignored mid-ramp target", dout[0], 32'h0040);

    send(1, 14'h2003, 8'd1, 16'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); lit("t6 tickdiv3 code", dout[1], seq6[i]);
    end
    @(posedge clk); #1;
    wait_idle(1, "t6 tickdiv3");

    send(0, 14'h3000, 8'd1, 16'd0);
    repeat (5) @(negedge clk);
    #2; rst[0] = 1'b1;
    #1;
    lit("t6 async reset code", dout[0], 32'h2000);
    lit("t6 async reset busy", busy[0], 0);
    lit("t6 async reset ready", trdy[0], 1);
    @(negedge clk); @(posedge clk); #1; rst[0] = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int g = 0; g < 2; g++) begin
        cur = (g == 0) ? gm[0].last : gm[1].last;
        rst[g] = ($urandom_range(0, 599) == 0);
        tv[g]  = ($urandom_range(0, 3) == 0);
        stl[g] = 16'($urandom_range(0, 4));
        case ($urandom_range(0, 7))
          0: begin
            t = int'(cur) + int'($urandom_range(0, 48)) - 24;
            if (t < 0) t = 0;
            if (t > 16383) t = 16383;
            tin[g] = W'(t);
            stp[g] = 8'($urandom_range(0, 3));
          end
          1: begin
            tin[g] = ($urandom_range(0, 1) == 0) ? 14'h0000 : 14'h3FFF;
            stp[g] = 8'($urandom_range(64, 255));
          end
          default: begin
            tin[g] = W'($urandom_range(0, 16383));
            stp[g] = 8'($urandom_range(64, 255));
          end
        endcase
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; tv[g] = 1'b0;
    end
    wait_idle(0, "random drain 0");
    wait_idle(1, "random drain 1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
